rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
Two-requester round-robin arbiter and read sequencer in front of a single synchronous ROM macro (rom_tech class, registered output, one-cycle read latency).
- Lets a bus-slave front end and a secondary reader (boot copier / debug reader) share one ROM instance without duplicating memory.
- Serialises reads, holds the ROM address stable until data is consumed, and applies per-port response backpressure.

Parameters:
abits, 12, ROM word-address width in bits.
dbits, 64, ROM data width in bits (CFG_SYSBUS_DATA_BITS in system use).

Ports:
i_clk  in  1  clock, all logic on rising edge
i_nrst  in  1  synchronous active-low reset
i_req0_valid  in  1  port 0 read request
i_req0_addr  in  abits  port 0 word address
o_req0_ready  out  1  port 0 request accepted this cycle
o_resp0_valid  out  1  port 0 read data valid
o_resp0_rdata  out  dbits  port 0 read data
i_resp0_ready  in  1  port 0 consumes response
i_req1_valid  in  1  port 1 read request
i_req1_addr  in  abits  port 1 word address
o_req1_ready  out  1  port 1 request accepted
o_resp1_valid  out  1  port 1 read data valid
o_resp1_rdata  out  dbits  port 1 read data
i_resp1_ready  in  1  port 1 consumes response
o_rom_addr  out  abits  address to ROM macro (registered)
i_rom_rdata  in  dbits  ROM data, valid one clock after address edge

Behaviour:
- Reset: i_nrst=0 sampled at a rising edge. State=IDLE, r_prio=0, r_sel=0, r_addr=0.
  - All outputs 0 in the following cycle: o_rom_addr, ready, resp_valid, rdata.
  - Any in-flight transaction is dropped; no response is ever issued for it.
- State register: IDLE, WAIT, RESP. r_sel: 1 bit, port in service. r_prio: 1 bit, port that wins a tie.
- IDLE:
  - Grant is combinational. If both valid, grant = r_prio. If one valid, grant = that port (work-conserving). If none, stay IDLE.
  - o_reqN_ready = 1 only for the granted port, only in IDLE. A handshake is ready&valid in the same cycle.
  - On grant: r_addr <= granted addr, r_sel <= grant, state -> WAIT.
- WAIT: exactly one cycle; ROM samples stable r_addr. state -> RESP. Both readies 0.
- RESP:
  - o_resp[r_sel]_valid = 1; o_resp[r_sel]_rdata = i_rom_rdata.
  - Non-selected port: valid 0, rdata 0.
  - r_addr is held, so data stays stable for the whole RESP state.
  - Both readies 0.
  - If i_resp[r_sel]_ready = 1: r_prio <= ~r_sel, state -> IDLE.
  - Otherwise remain in RESP indefinitely; valid and data stay stable.
  - i_resp ready of the non-selected port is ignored.
- o_rom_addr = r_addr at all times (registered, glitch-free).
- Latency and throughput:
  - Handshake at cycle T gives resp_valid from T+2.
  - Minimum spacing between grants is 3 cycles (IDLE, WAIT, RESP with immediate ready).
- Fairness: with both ports requesting continuously, grants strictly alternate. A waiting port is served within one foreign transaction.
- Requester may drop or change valid/addr while not granted; only the handshake cycle's addr is used.
- Reset asserted in WAIT or RESP: next cycle IDLE, outputs 0, r_prio = 0.

Test Plan:
1. Port0 only, addr 0x010 at cycle T, ROM[0x010]=0x0123456789ABCDEF, i_resp0_ready=1 -> o_req0_ready=1 at T; o_rom_addr=0x010 from T+1; o_resp0_valid=1 with 0x0123456789ABCDEF at T+2 only; port1 outputs 0 throughout.
2. After reset, both valid same cycle (addr0=0x001, addr1=0x002), resp ready high -> port0 granted at T, resp at T+2; port1 granted at T+3, resp at T+5 with ROM[0x002].
3. Both ports requesting continuously for 8 transactions -> grant sequence 0,1,0,1,0,1,0,1; every response data matches the granted address.
4. Port1 served, resp1_ready held 0 for 5 cycles while port0 valid -> o_resp1_valid and rdata constant for 6 cycles; o_req0_ready stays 0; port0 granted in the cycle after resp1_ready=1.
5. r_prio=1 (after port0 served), only port0 valid with addr 0xFFF -> port0 granted immediately (no idle wait); rdata = ROM[0xFFF] (top address, no wrap error).
6. Reset pulsed during WAIT of port0 read -> next cycle all outputs 0 and state IDLE; no o_resp0_valid is ever produced for the dropped read; a subsequent port0 request completes normally with 2-cycle latency.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter and read sequencer in front of a single
// synchronous ROM macro with a one-cycle registered read latency.
//
// Handshake semantics: a request transfers in the cycle where reqN_valid and
// o_reqN_ready are both high; a response transfers in the cycle where
// o_respN_valid and i_respN_ready are both high. Once raised, o_respN_valid
// and o_respN_rdata hold steady until that transfer happens. A requester may
// change or drop valid/addr freely while it is not being accepted.
module rom_arbiter #(
  parameter int abits = 12,
  parameter int dbits = 64
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_req0_valid,
  input  logic [abits-1:0] i_req0_addr,
  output logic             o_req0_ready,
  output logic             o_resp0_valid,
  output logic [dbits-1:0] o_resp0_rdata,
  input  logic             i_resp0_ready,
  input  logic             i_req1_valid,
  input  logic [abits-1:0] i_req1_addr,
  output logic             o_req1_ready,
  output logic             o_resp1_valid,
  output logic [dbits-1:0] o_resp1_rdata,
  input  logic             i_resp1_ready,
  output logic [abits-1:0] o_rom_addr,
  input  logic [dbits-1:0] i_rom_rdata,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;     // port currently in service
  logic             prio_q, prio_d;   // port that wins a tie
  logic [abits-1:0] addr_q, addr_d;   // address presented to the ROM
  logic             grant;

  // State and datapath registers; reset drops any in-flight read.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
    end
  end

  // Grant selection, next-state logic and all handshake outputs.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    prio_d        = prio_q;
    addr_d        = addr_q;
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    o_resp0_valid = 1'b0;
    o_resp1_valid = 1'b0;
    o_resp0_rdata = '0;
    o_resp1_rdata = '0;
    // Tie goes to prio_q; a lone requester always wins (work-conserving).
    grant = (i_req0_valid && i_req1_valid) ? prio_q : i_req1_valid;

    case (state_q)
      ST_IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          o_req0_ready = ~grant;
          o_req1_ready = grant;
          addr_d       = grant ? i_req1_addr : i_req0_addr;
          sel_d        = grant;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // ROM samples the stable address on this cycle's closing edge.
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Address is held, so ROM data stays stable for the whole stall.
        if (!sel_q) begin
          o_resp0_valid = 1'b1;
          o_resp0_rdata = i_rom_rdata;
          if (i_resp0_ready) begin
            prio_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          o_resp1_valid = 1'b1;
          o_resp1_rdata = i_rom_rdata;
          if (i_resp1_ready) begin
            prio_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_rom_addr  = addr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model and a response scoreboard.
module tb_rom_arbiter;

  localparam int AW = 12;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata = '0;
  logic [1:0]    dbg_state;

  rom_arbiter #(.abits(AW), .dbits(DW)) dut (
    .i_clk         (clk),
    .i_nrst        (rst_n),
    .i_req0_valid  (req0_valid),
    .i_req0_addr   (req0_addr),
    .o_req0_ready  (req0_ready),
    .o_resp0_valid (resp0_valid),
    .o_resp0_rdata (resp0_rdata),
    .i_resp0_ready (resp0_ready),
    .i_req1_valid  (req1_valid),
    .i_req1_addr   (req1_addr),
    .o_req1_ready  (req1_ready),
    .o_resp1_valid (resp1_valid),
    .o_resp1_rdata (resp1_rdata),
    .i_resp1_ready (resp1_ready),
    .o_rom_addr    (rom_addr),
    .i_rom_rdata   (rom_rdata),
    .o_dbg_state   (dbg_state)
  );

  // ROM macro model: registered output, one-cycle latency.
  logic [DW-1:0] rom [4096];
  always @(posedge clk) rom_rdata <= rom[rom_addr];

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;
  logic [DW:0] exp_q[$];   // {port, data} of each accepted read
  int grant_log[$];        // ports seen handshaking, in order

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Arbiter is either free or serving one read granted at cycle m_t;
  // the response is due from m_t+2 until the served port accepts it.
  bit          m_busy = 1'b0, m_sel = 1'b0, m_prio = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int          m_t = 0, cyc = 0;

  always @(negedge clk) begin
    bit er0, er1, in_resp, win;
    if (checking) begin
      er0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
      er1 = !m_busy && req1_valid && (!req0_valid ||  m_prio);
      in_resp = m_busy && (cyc >= m_t + 2);
      chk("req0_ready",  128'(req0_ready),  128'(er0));
      chk("req1_ready",  128'(req1_ready),  128'(er1));
      chk("resp0_valid", 128'(resp0_valid), 128'(in_resp && !m_sel));
      chk("resp1_valid", 128'(resp1_valid), 128'(in_resp &&  m_sel));
      chk("rom_addr",    128'(rom_addr),    128'(m_addr));
      if (!rst_n) begin
        m_busy = 1'b0; m_prio = 1'b0; m_addr = '0;
      end else if (er0 || er1) begin
        win    = er1;
        m_addr = win ? req1_addr : req0_addr;
        exp_q.push_back({win, rom[m_addr]});
        m_busy = 1'b1; m_sel = win; m_t = cyc;
      end else if (in_resp && (m_sel ? resp1_ready : resp0_ready)) begin
        m_busy = 1'b0; m_prio = ~m_sel;
      end
    end
    cyc++;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DW:0] front;
    if (checking) begin
      if (req0_valid && req0_ready) grant_log.push_back(0);
      if (req1_valid && req1_ready) grant_log.push_back(1);
      if (!resp0_valid) chk("resp0_rdata_idle", 128'(resp0_rdata), 128'(0));
      if (!resp1_valid) chk("resp1_rdata_idle", 128'(resp1_rdata), 128'(0));
      if (resp0_valid || resp1_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp_unexpected: got valid0=%0b valid1=%0b expected none", resp0_valid, resp1_valid);
        end else begin
          front = exp_q[0];
          chk("resp_port", 128'(resp1_valid), 128'(front[DW]));
          chk("resp_rdata", 128'(resp1_valid ? resp1_rdata : resp0_rdata), 128'(front[DW-1:0]));
          if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) void'(exp_q.pop_front());
        end
      end
      if (!rst_n) exp_q.delete();
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the inputs for n cycles.
  task automatic drive(input bit v0, input int a0, input bit v1, input int a1,
                       input bit r0, input bit r1, input int n);
    req0_valid = v0; req0_addr = AW'(a0);
    req1_valid = v1; req1_addr = AW'(a1);
    resp0_ready = r0; resp1_ready = r1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = {$urandom, $urandom};
    rom[12'h010] = 64'h0123456789ABCDEF;
    rom[12'hFFF] = 64'hFEEDFACECAFEBEEF;

    @(posedge clk); #1;
    checking = 1'b1;
    do_reset();

    // Reset state and port0-only read.
    drive(0, 0, 0, 0, 1, 1, 2);
    drive(1, 'h010, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 4);

    // Simultaneous requests right after reset: port0 first, then port1.
    do_reset();
    drive(1, 'h001, 1, 'h002, 1, 1, 1);
    drive(0, 0, 1, 'h002, 1, 1, 3);
    drive(0, 0, 0, 0, 1, 1, 4);

    // Continuous contention: grants must alternate 0,1,0,1...
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 24; i++)
      drive(1, $urandom_range(0, 4095), 1, $urandom_range(0, 4095), 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 4);
    chk("alt_count", 128'(grant_log.size()), 128'(8));
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk("alt_grant", 128'(grant_log[i]), 128'(i % 2));

    // Port1 response stalled while port0 waits.
    do_reset();
    drive(0, 0, 1, 'h123, 1, 1, 1);
    drive(1, 'h055, 0, 0, 1, 0, 6);
    drive(1, 'h055, 0, 0, 1, 1, 1);
    drive(1, 'h055, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 4);

    // Tie priority now favours port1; port0 alone must still win at once.
    drive(1, 'hFFF, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 4);

    // Reset during WAIT drops the read; a following read completes normally.
    drive(1, 'h020, 0, 0, 1, 1, 1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 1);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 3);
    drive(1, 'h030, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 4);

    // Randomized traffic with backpressure and occasional reset.
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 4095),
            $urandom_range(0, 1), $urandom_range(0, 4095),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 6);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
